// File: rtl/msg_streamer.sv
// Paced ASCII message streamer: plays one of four constant ROM strings
// over a valid/ready interface, with an optional inter-character gap and a loop mode.
module msg_streamer #(
  parameter int DIV_W = 8,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       msg_sel,
  input  logic             loop,
  input  logic [DIV_W-1:0] div,
  input  logic             ready,
  output logic [7:0]       data,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  localparam logic [8*21-1:0] MSG0 = "Tajumulco Tacana Acat";
  localparam logic [8*13-1:0] MSG1 = "Soy de Zacapa";
  localparam logic [8*4-1:0]  MSG2 = "HOLA";
  localparam logic [8*10-1:0] MSG3 = "0123456789";

  // Characters are packed first-character-in-MSB, as the string literals lay them out.
  function automatic logic [7:0] rom_char(input logic [1:0] sel, input logic [LEN_W-1:0] idx);
    logic [7:0] c;
    int         i;
    c = 8'h00;
    i = int'(idx);
    case (sel)
      2'd0:    if (i < 21) c = MSG0[8*(20-i) +: 8];
      2'd1:    if (i < 13) c = MSG1[8*(12-i) +: 8];
      2'd2:    if (i < 4)  c = MSG2[8*(3-i)  +: 8];
      default: if (i < 10) c = MSG3[8*(9-i)  +: 8];
    endcase
    return c;
  endfunction

  function automatic logic [LEN_W-1:0] last_idx(input logic [1:0] sel);
    logic [LEN_W-1:0] l;
    case (sel)
      2'd0:    l = LEN_W'(20);
      2'd1:    l = LEN_W'(12);
      2'd2:    l = LEN_W'(3);
      default: l = LEN_W'(9);
    endcase
    return l;
  endfunction

  state_e           state_q, state_d;
  logic [LEN_W-1:0] idx_q, idx_d, idx_nxt;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       sel_q, sel_d;
  logic             loop_q, loop_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;
  logic             is_last, hs;

  assign valid   = en && (state_q == SEND);
  assign hs      = valid && ready;
  assign busy    = (state_q != IDLE);
  assign data    = data_q;
  assign done    = done_q;
  assign is_last = (idx_q == last_idx(sel_q));
  assign idx_nxt = is_last ? '0 : idx_q + LEN_W'(1);

  always_comb begin
    // NOTE: every _d gets a default (hold) first so no path leaves it unassigned and infers a latch.
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    sel_d   = sel_q;
    loop_d  = loop_q;
    data_d  = data_q;
    done_d  = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_d = SEND;
            sel_d   = msg_sel;
            loop_d  = loop;
            div_d   = div;
            idx_d   = '0;
            cnt_d   = '0;
            data_d  = rom_char(msg_sel, '0);
          end
        end
        SEND: begin
          // A stop coinciding with a handshake still delivers that character, then ends quietly.
          if (stop) begin
            state_d = IDLE;
          end else if (hs) begin
            if (is_last && !loop_q) begin
              state_d = IDLE;
              idx_d   = '0;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_nxt;
              if (div_q == '0) begin
                data_d = rom_char(sel_q, idx_nxt);
              end else begin
                state_d = GAP;
                cnt_d   = div_q;
              end
            end
          end
        end
        GAP: begin
          if (stop) begin
            state_d = IDLE;
          end else if (cnt_q <= DIV_W'(1)) begin
            state_d = SEND;
            cnt_d   = '0;
            data_d  = rom_char(sel_q, idx_q);
          end else begin
            cnt_d = cnt_q - DIV_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      sel_q   <= '0;
      loop_q  <= 1'b0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sel_q   <= sel_d;
      loop_q  <= loop_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_msg_streamer.sv
// Self-checking bench for msg_streamer: scoreboard of expected characters popped on
// every valid&ready handshake, plus per-scenario timing and control checks.
module tb_msg_streamer;

  logic       clk = 1'b0;
  logic       rst, en, start, stop, loop, ready;
  logic [1:0] msg_sel;
  logic [7:0] div;
  logic [7:0] data;
  logic       valid, busy, done;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int done_count = 0;
  logic [7:0] sb[$];
  logic       s_valid, s_busy, s_done;
  logic [7:0] s_data;
  string      msgs[4];

  msg_streamer #(.DIV_W(8), .LEN_W(5)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop),
    .msg_sel(msg_sel), .loop(loop), .div(div), .ready(ready),
    .data(data), .valid(valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Inputs are set just after a falling edge; outputs are sampled 1 ns later,
  // before the rising edge that acts on them.
  task automatic step();
    logic [7:0] exp_c;
    #1;
    s_valid = valid;
    s_data  = data;
    s_busy  = busy;
    s_done  = done;
    if (valid && ready) begin
      hs_count++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got char %h, expected none", data);
      end else begin
        exp_c = sb.pop_front();
        if (data !== exp_c) begin
          errors++;
          $display("FAIL sb_data: got %h, expected %h", data, exp_c);
        end
      end
    end
    if (done) done_count++;
    @(negedge clk);
  endtask

  task automatic push_msg(input int s);
    for (int i = 0; i < msgs[s].len(); i++) sb.push_back(msgs[s][i]);
  endtask

  task automatic run_until_done(input int max, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < max && !seen; k++) begin
      step();
      if (s_done) seen = 1'b1;
    end
  endtask

  task automatic check_end(input string name, input bit seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done: got no done pulse, expected one", name);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_sb_empty: got %0d pending chars, expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
    ready = 1'b0; msg_sel = 2'd0; div = 8'd0;
    step(); step();
    rst = 1'b0;
    step();
    checks++;
    if (s_data !== 8'h00 || s_valid !== 1'b0 || s_busy !== 1'b0 || s_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h valid=%b busy=%b done=%b, expected 00 0 0 0",
               s_data, s_valid, s_busy, s_done);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_b[4];
    exp_b = '{8'h48, 8'h4F, 8'h4C, 8'h41};
    sb.delete(); push_msg(2);
    msg_sel = 2'd2; loop = 1'b0; div = 8'd0; ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (s_valid !== 1'b1 || s_data !== exp_b[i]) begin
        errors++;
        $display("FAIL basic_char%0d: got valid=%b data=%h, expected 1 %h", i, s_valid, s_data, exp_b[i]);
      end
    end
    step();
    checks++;
    if (s_done !== 1'b1 || s_busy !== 1'b0 || s_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got done=%b busy=%b valid=%b, expected 1 0 0", s_done, s_busy, s_valid);
    end
    step();
    checks++;
    if (s_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_width: got done=%b, expected 0", s_done);
    end
    check_end("basic", 1'b1);
  endtask

  task automatic test_gap();
    int first = -1, last = -1, prev = -1, nvalid = 0, bad_gap = 0;
    bit seen = 1'b0;
    sb.delete(); push_msg(2);
    msg_sel = 2'd2; loop = 1'b0; div = 8'd3; ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0; div = 8'd0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      if (s_valid) begin
        if (first < 0) first = k;
        if (prev >= 0 && k - prev != 4) bad_gap++;
        prev = k; last = k; nvalid++;
      end
      if (s_done) seen = 1'b1;
    end
    checks++;
    if (nvalid != 4) begin
      errors++;
      $display("FAIL gap_count: got %0d valid cycles, expected 4", nvalid);
    end
    checks++;
    if (last - first + 1 != 13) begin
      errors++;
      $display("FAIL gap_span: got %0d cycles, expected 13", last - first + 1);
    end
    checks++;
    if (bad_gap != 0) begin
      errors++;
      $display("FAIL gap_spacing: got %0d irregular gaps, expected 0", bad_gap);
    end
    check_end("gap", seen);
  endtask

  task automatic test_backpressure();
    logic ready_pat[4];
    int  h0;
    bit  seen;
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    sb.delete(); push_msg(1);
    h0 = hs_count;
    msg_sel = 2'd1; loop = 1'b0; div = 8'd0; ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ready = ready_pat[k];
      step();
      if (k > 0) begin
        checks++;
        if (s_valid !== 1'b1 || s_data !== 8'h6F) begin
          errors++;
          $display("FAIL bp_hold%0d: got valid=%b data=%h, expected 1 6f", k, s_valid, s_data);
        end
      end
    end
    ready = 1'b1;
    run_until_done(30, seen);
    checks++;
    if (hs_count - h0 != 13) begin
      errors++;
      $display("FAIL bp_hs_count: got %0d handshakes, expected 13", hs_count - h0);
    end
    check_end("bp", seen);
  endtask

  task automatic test_loop_stop();
    int d0;
    sb.delete();
    for (int i = 0; i < 15; i++) sb.push_back(msgs[3][i % 10]);
    d0 = done_count;
    msg_sel = 2'd3; loop = 1'b1; div = 8'd0; ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0; loop = 1'b0;
    for (int k = 0; k < 15; k++) begin
      stop = (k == 14);
      step();
      if (k == 9 || k == 10) begin
        checks++;
        if (s_valid !== 1'b1 || s_data !== (k == 9 ? 8'h39 : 8'h30)) begin
          errors++;
          $display("FAIL loop_wrap%0d: got valid=%b data=%h, expected 1 %h",
                   k, s_valid, s_data, (k == 9 ? 8'h39 : 8'h30));
        end
      end
    end
    stop = 1'b0;
    step();
    checks++;
    if (s_valid !== 1'b0 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL loop_stop: got valid=%b busy=%b, expected 0 0", s_valid, s_busy);
    end
    checks++;
    if (done_count != d0) begin
      errors++;
      $display("FAIL loop_no_done: got %0d done pulses, expected 0", done_count - d0);
    end
    check_end("loop", 1'b1);
  endtask

  task automatic test_enable();
    int  h0;
    bit  seen;
    logic [7:0] held;
    held = msgs[0][8];
    sb.delete(); push_msg(0);
    h0 = hs_count;
    msg_sel = 2'd0; loop = 1'b0; div = 8'd0; ready = 1'b1; en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) step();
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (s_valid !== 1'b0 || s_data !== held) begin
        errors++;
        $display("FAIL en_freeze%0d: got valid=%b data=%h, expected 0 %h", k, s_valid, s_data, held);
      end
    end
    en = 1'b1;
    run_until_done(40, seen);
    checks++;
    if (hs_count - h0 != 21) begin
      errors++;
      $display("FAIL en_hs_count: got %0d handshakes, expected 21", hs_count - h0);
    end
    check_end("en", seen);
  endtask

  task automatic test_reset_mid();
    bit seen;
    sb.delete(); push_msg(0);
    msg_sel = 2'd0; loop = 1'b1; div = 8'd2; ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0; loop = 1'b0; div = 8'd0;
    for (int k = 0; k < 5; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    step();
    checks++;
    if (s_data !== 8'h00 || s_valid !== 1'b0 || s_busy !== 1'b0 || s_done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: got data=%h valid=%b busy=%b done=%b, expected 00 0 0 0",
               s_data, s_valid, s_busy, s_done);
    end
    push_msg(1);
    msg_sel = 2'd1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++;
    if (s_valid !== 1'b1 || s_data !== 8'h53) begin
      errors++;
      $display("FAIL rstmid_first: got valid=%b data=%h, expected 1 53", s_valid, s_data);
    end
    run_until_done(30, seen);
    check_end("rstmid", seen);
  endtask

  task automatic test_start_ignored();
    bit seen;
    sb.delete(); push_msg(2);
    msg_sel = 2'd2; loop = 1'b0; div = 8'd0; ready = 1'b0; start = 1'b1;
    step();
    msg_sel = 2'd3; loop = 1'b1; div = 8'd5;
    step();
    start = 1'b0; msg_sel = 2'd0; loop = 1'b0; div = 8'd0;
    step();
    checks++;
    if (s_valid !== 1'b1 || s_data !== 8'h48) begin
      errors++;
      $display("FAIL ignore_start: got valid=%b data=%h, expected 1 48", s_valid, s_data);
    end
    ready = 1'b1;
    run_until_done(20, seen);
    check_end("ignore", seen);
  endtask

  task automatic test_stop_idle();
    sb.delete();
    ready = 1'b1; stop = 1'b1;
    step();
    step();
    checks++;
    if (s_busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_idle: got busy=%b, expected 0", s_busy);
    end
    start = 1'b1; msg_sel = 2'd2;
    step();
    start = 1'b0; stop = 1'b0;
    step();
    checks++;
    if (s_busy !== 1'b0 || s_valid !== 1'b0) begin
      errors++;
      $display("FAIL stop_start_idle: got busy=%b valid=%b, expected 0 0", s_busy, s_valid);
    end
  endtask

  initial begin
    msgs[0] = "Tajumulco Tacana Acat";
    msgs[1] = "Soy de Zacapa";
    msgs[2] = "HOLA";
    msgs[3] = "0123456789";
    rst = 1'b1; en = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
    ready = 1'b0; msg_sel = 2'd0; div = 8'd0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_gap();
    test_backpressure();
    test_loop_stop();
    test_enable();
    test_reset_mid();
    test_start_ignored();
    test_stop_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msg_streamer.md
MSG_STREAMER -- requirements
Module: msg_streamer

Interface
REQ-001 Parameter DIV_W, default 8: width of the inter-character pacing divider.
REQ-002 Parameter LEN_W, default 5: width of the character index; each message SHALL be at most 2^LEN_W characters long.
REQ-003 clk  input  1  rising-edge clock; the single clock domain.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 en  input  1  global enable; when low, all state is frozen.
REQ-006 start  input  1  one-cycle request to begin streaming the selected message.
REQ-007 stop  input  1  abort request for the current stream.
REQ-008 msg_sel  input  2  message select, sampled at start.
REQ-009 loop  input  1  repeat-mode select, sampled at start.
REQ-010 div  input  DIV_W  idle cycles inserted between characters, sampled at start.
REQ-011 ready  input  1  downstream sink can accept a character.
REQ-012 data  output  8  current ASCII character.
REQ-013 valid  output  1  data is valid.
REQ-014 busy  output  1  a stream is in progress.
REQ-015 done  output  1  one-cycle pulse when a non-loop stream completes.

Function
REQ-016 The internal constant ROM SHALL hold these messages.
- msg 0: "Tajumulco Tacana Acat", 21 characters.
- msg 1: "Soy de Zacapa", 13 characters.
- msg 2: "HOLA", 4 characters.
- msg 3: "0123456789", 10 characters.
REQ-017 Each message's length SHALL be stored as a constant; no terminator character is emitted.
REQ-018 The FSM SHALL have exactly these states: IDLE, SEND, GAP.
REQ-019 IDLE to SEND: on start=1 with en=1.
- msg_sel, loop and div are latched in the same cycle.
- The index is set to 0.
REQ-020 SEND behaviour:
- valid=1.
- data = ROM[sel][index].
- data SHALL stay stable until a handshake.
- Handshake = valid & ready on a rising clk edge.
REQ-021 Handshake on a character that is not last: index increments.
- If the latched div = 0, stay in SEND, so characters go back-to-back at 1 char/cycle when ready=1.
- If div > 0, go to GAP with the pacing counter loaded with div.
REQ-022 GAP behaviour:
- valid=0.
- The counter decrements each en cycle.
- The FSM returns to SEND in the cycle after the counter reaches 1, giving exactly div cycles with valid=0 between characters.
REQ-023 Handshake on the last character, latched loop=1:
- index wraps to 0.
- The FSM proceeds to GAP or SEND per REQ-021.
- The stream repeats indefinitely.
REQ-024 Handshake on the last character, latched loop=0:
- Next state is IDLE.
- done=1 for exactly one cycle, the cycle after the handshake.
- busy=0 in that same cycle.
REQ-025 busy SHALL be 1 in SEND and GAP, and 0 in IDLE.
REQ-026 start while busy=1 SHALL be ignored, including any new msg_sel, loop and div values.
REQ-027 stop=1 with en=1 in SEND or GAP:
- Next state is IDLE.
- valid=0 next cycle.
- No done pulse.
REQ-028 stop and a handshake in the same cycle: the character counts as delivered, stop wins, and no further characters follow.
REQ-029 stop in IDLE SHALL have no effect; stop and start together in IDLE SHALL stay in IDLE.
REQ-030 Start latency: the first character SHALL be valid in the cycle after start is sampled.
REQ-031 When en=0:
- State, index and counter SHALL hold.
- valid is forced to 0, so no handshake can occur.
- start and stop are ignored.
- The stream resumes unchanged when en returns to 1.
REQ-032 In IDLE and GAP, data SHALL hold its last driven value.

Reset
REQ-033 rst=1 at a rising edge SHALL set:
- state to IDLE.
- data=8'h00, valid=0, busy=0, done=0.
- index=0, pacing counter=0.
- latched sel, loop and div to 0.
REQ-034 rst SHALL take priority over en, start, stop and an in-progress stream, including mid-GAP and the cycle of a done pulse.

Verification
REQ-035 msg_sel=2, loop=0, div=0, ready=1 held, start pulse.
- data = 8'h48, 8'h4F, 8'h4C, 8'h41 on 4 consecutive cycles with valid=1.
- Then done=1 for one cycle and busy=0.
REQ-036 msg_sel=2, div=3, ready=1: exactly 3 valid=0 cycles between each character; the stream takes 4+3*3 = 13 cycles from the first valid to the last.
REQ-037 msg_sel=1, ready toggled 1,0,0,1 during SEND: data holds 8'h6F ('o') stable through the ready=0 cycles; no character is skipped or duplicated.
REQ-038 msg_sel=3, loop=1, div=0, ready=1:
- After 8'h39 the next character is 8'h30.
- No done pulse occurs.
- stop on character 15 gives valid=0 next cycle and busy=0.
REQ-039 msg_sel=0, en dropped low for 5 cycles mid-stream: valid=0 for those cycles, then the sequence resumes at the same index; the full 21-character string is received intact.
REQ-040 rst asserted mid-stream, then start with msg_sel=1: all outputs are 0 after reset, and the first character is 8'h53 ('S').
